// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and helpers for the bit-serial pattern detector.
//   - default pattern length, pattern and counter width
//   - fill-state encoding: the fill counter (0..LEN) is the detector FSM
//   - saturating maximum of the default-width match counter
// -----------------------------------------------------------------------------
package seq_det_pkg;

  localparam int          DEF_LEN     = 4;
  // Stored 16 bits wide so any LEN up to 16 can slice its default from it.
  localparam logic [15:0] DEF_PATTERN = 16'h000B;
  localparam int          DEF_CNT_W   = 8;
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = {DEF_CNT_W{1'b1}};

  // Fill-state encoding: EMPTY is zero, ARMED equals the pattern length.
  localparam int FILL_EMPTY       = 0;
  localparam int DEF_FILL_ARMED   = DEF_LEN;

  // Coarse phase of the fill counter, used to steer next-state decoding.
  typedef enum logic [1:0] {
    PH_EMPTY   = 2'd0,
    PH_FILLING = 2'd1,
    PH_ARMED   = 2'd2
  } fill_phase_e;

  // Classify a fill count against the pattern length.
  function automatic fill_phase_e fill_phase(input int fill, input int len);
    fill_phase_e ph;
    if (fill == FILL_EMPTY) begin
      ph = PH_EMPTY;
    end else if (fill >= len) begin
      ph = PH_ARMED;
    end else begin
      ph = PH_FILLING;
    end
    return ph;
  endfunction

endpackage

// File: rtl/seq_det_serial_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// CNT_W-wide up counter that saturates at all-ones and never wraps.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset (count -> 0)
//   inc    in   add one unless already saturated
//   clr    in   synchronous clear; has priority over inc
//   cnt    out  registered count
// -----------------------------------------------------------------------------
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Count register: reset, clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/seq_det_serial.sv
// -----------------------------------------------------------------------------
// seq_det_serial
// Bit-serial pattern detector. Each accepted bit is shifted into a LEN-bit
// history (MSB = oldest bit). When the shifted history equals PATTERN and at
// least LEN bits have been seen, a one-cycle registered detect pulse follows.
// A saturating match counter and an optional sticky flag track matches.
//
// Build option: define SEQ_DET_STICKY_EN to build the sticky `seen` flag;
// otherwise `seen` is tied low (port list unchanged).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   din_valid  in   qualifies din; bit consumed only when high
//   din        in   serial data bit
//   clr        in   synchronous clear of match_cnt and seen (history kept)
//   detect     out  one-cycle match pulse, registered
//   match_cnt  out  saturating match count since reset/clr
//   seen       out  sticky match flag (SEQ_DET_STICKY_EN builds only)
// -----------------------------------------------------------------------------
module seq_det_serial
  import seq_det_pkg::*;
#(
  parameter int             LEN     = DEF_LEN,
  parameter logic [LEN-1:0] PATTERN = DEF_PATTERN[LEN-1:0],
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr,
  output logic             detect,
  output logic [CNT_W-1:0] match_cnt,
  output logic             seen
);

  localparam int               FILL_W         = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_EMPTY_V  = FILL_W'(FILL_EMPTY);
  localparam logic [FILL_W-1:0] FILL_ARMED_V  = FILL_W'(LEN);
  // A match is possible once LEN-1 bits are held and the LEN-th arrives.
  localparam logic [FILL_W-1:0] FILL_MATCH_MIN = FILL_W'(LEN - 1);
  localparam logic [FILL_W-1:0] FILL_ONE       = FILL_W'(1);

  logic [LEN-1:0]    hist_r;
  logic [LEN-1:0]    hist_next_s;
  logic [LEN-1:0]    hist_shift_s;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_next_s;
  logic [FILL_W-1:0] fill_inc_s;
  fill_phase_e       phase_s;
  logic              match_s;
  logic              detect_r;

  // Next-state decode for history and fill FSM, plus the match compare.
  always_comb begin
    hist_shift_s = {hist_r[LEN-2:0], din};
    phase_s      = fill_phase(int'(fill_r), LEN);
    hist_next_s  = hist_r;
    fill_next_s  = fill_r;
    fill_inc_s   = fill_r;
    match_s      = 1'b0;

    if (din_valid) begin
      case (phase_s)
        PH_EMPTY: begin
          fill_inc_s = fill_r + FILL_ONE;
          match_s    = 1'b0;
        end
        PH_FILLING: begin
          fill_inc_s = fill_r + FILL_ONE;
          match_s    = (fill_r >= FILL_MATCH_MIN) && (hist_shift_s == PATTERN);
        end
        PH_ARMED: begin
          fill_inc_s = FILL_ARMED_V;
          match_s    = (hist_shift_s == PATTERN);
        end
        default: begin
          fill_inc_s = FILL_EMPTY_V;
          match_s    = 1'b0;
        end
      endcase

      // Non-overlapping mode discards all history after a match.
      if (match_s && (OVERLAP == 0)) begin
        hist_next_s = {LEN{1'b0}};
        fill_next_s = FILL_EMPTY_V;
      end else begin
        hist_next_s = hist_shift_s;
        fill_next_s = fill_inc_s;
      end
    end else begin
      hist_next_s = hist_r;
      fill_next_s = fill_r;
    end
  end

  // History, fill state and detect pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_r   <= {LEN{1'b0}};
      fill_r   <= FILL_EMPTY_V;
      detect_r <= 1'b0;
    end else begin
      hist_r   <= hist_next_s;
      fill_r   <= fill_next_s;
      detect_r <= match_s;
    end
  end

  assign detect = detect_r;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match_s),
    .clr   (clr),
    .cnt   (match_cnt)
  );

`ifdef SEQ_DET_STICKY_EN
  logic seen_r;

  // Sticky flag: set by any match, cleared by clr (clr wins) or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_r <= 1'b0;
    end else if (clr) begin
      seen_r <= 1'b0;
    end else if (match_s) begin
      seen_r <= 1'b1;
    end else begin
      seen_r <= seen_r;
    end
  end

  assign seen = seen_r;
`else
  assign seen = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_serial.sv
// -----------------------------------------------------------------------------
// tb_seq_det_serial
// Three detectors share one stimulus stream: overlapping (8-bit count),
// non-overlapping, and overlapping with a 2-bit count. A reference model
// produces expected outputs per cycle into queues, popped after each edge.
// -----------------------------------------------------------------------------
module tb_seq_det_serial;

  logic       clk;
  logic       rst_n;
  logic       din_valid;
  logic       din;
  logic       clr;

  logic       det_ov, det_no, det_c2;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_c2;
  logic       seen_ov, seen_no, seen_c2;

  int total = 0;
  int bad   = 0;
  int t_ov, t_no, t_c2;

  typedef struct packed {
    logic [3:0] hist;
    logic [2:0] fill;
    logic [7:0] cnt;
    logic       seen;
    logic       det;
  } mst_t;

  mst_t m_ov, m_no, m_c2;
  mst_t q_ov[$];
  mst_t q_no[$];
  mst_t q_c2[$];

  seq_det_serial #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
    .detect(det_ov), .match_cnt(cnt_ov), .seen(seen_ov));

  seq_det_serial #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_no (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
    .detect(det_no), .match_cnt(cnt_no), .seen(seen_no));

  seq_det_serial #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
    .detect(det_c2), .match_cnt(cnt_c2), .seen(seen_c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one detector for one clock edge.
  function automatic mst_t mstep(input mst_t s, input bit ov, input int cmax,
                                 input bit v, input bit d, input bit c, input bit r);
    mst_t n;
    logic [3:0] sh;
    n = s;
    n.det = 1'b0;
    if (!r) begin
      n = '0;
      return n;
    end
    if (v) begin
      sh = {s.hist[2:0], d};
      if (s.fill >= 3 && sh == 4'b1011) n.det = 1'b1;
      if (n.det && !ov) begin
        n.hist = 4'b0000;
        n.fill = 3'd0;
      end else begin
        n.hist = sh;
        n.fill = (s.fill == 3'd4) ? 3'd4 : s.fill + 3'd1;
      end
    end
    if (c) begin
      n.cnt  = 8'd0;
      n.seen = 1'b0;
    end else if (n.det) begin
      n.seen = 1'b1;
      if (int'(s.cnt) < cmax) n.cnt = s.cnt + 8'd1;
    end
    return n;
  endfunction

  function automatic int exp_seen(input mst_t e);
`ifdef SEQ_DET_STICKY_EN
    return int'(e.seen);
`else
    return 0;
`endif
  endfunction

  // One clock: drive inputs, queue model expectations, check after the edge.
  task automatic cyc(input bit v, input bit d, input bit c, input bit r);
    mst_t e;
    din_valid = v; din = d; clr = c; rst_n = r;
    m_ov = mstep(m_ov, 1'b1, 255, v, d, c, r); q_ov.push_back(m_ov);
    m_no = mstep(m_no, 1'b0, 255, v, d, c, r); q_no.push_back(m_no);
    m_c2 = mstep(m_c2, 1'b1, 3,   v, d, c, r); q_c2.push_back(m_c2);
    @(posedge clk);
    #1;
    e = q_ov.pop_front();
    chk("ov_det", int'(det_ov), int'(e.det));
    chk("ov_cnt", int'(cnt_ov), int'(e.cnt));
    chk("ov_seen", int'(seen_ov), exp_seen(e));
    e = q_no.pop_front();
    chk("no_det", int'(det_no), int'(e.det));
    chk("no_cnt", int'(cnt_no), int'(e.cnt));
    chk("no_seen", int'(seen_no), exp_seen(e));
    e = q_c2.pop_front();
    chk("c2_det", int'(det_c2), int'(e.det));
    chk("c2_cnt", int'(cnt_c2), int'(e.cnt));
    chk("c2_seen", int'(seen_c2), exp_seen(e));
    if (det_ov) t_ov++;
    if (det_no) t_no++;
    if (det_c2) t_c2++;
  endtask

  task automatic feed(input string bits);
    for (int i = 0; i < bits.len(); i++) begin
      cyc(1'b1, bits[i] == "1", 1'b0, 1'b1);
    end
  endtask

  task automatic clear_tally();
    t_ov = 0; t_no = 0; t_c2 = 0;
  endtask

  initial begin
    m_ov = '0; m_no = '0; m_c2 = '0;
    rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; clr = 1'b0;
    clear_tally();

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_det", int'(det_ov), 0);
    chk("rst_cnt", int'(cnt_ov), 0);

    // 1: overlapping vs non-overlapping on 1011011
    clear_tally();
    feed("1011011");
    chk("t1_ov_pulses", t_ov, 2);
    chk("t1_ov_cnt", int'(cnt_ov), 2);
    chk("t1_no_pulses", t_no, 1);
    chk("t1_no_cnt", int'(cnt_no), 1);

    // 3: valid gaps are transparent
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    clear_tally();
    feed("10");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("t3_gap_pulses", t_ov, 0);
    feed("1");
    chk("t3_pre_pulses", t_ov, 0);
    feed("1");
    chk("t3_det_now", int'(det_ov), 1);
    chk("t3_pulses", t_ov, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_pulse_width", int'(det_ov), 0);

    // 4: saturation with a 2-bit counter
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    clear_tally();
    feed("1011011011011011");
    chk("t4_c2_pulses", t_c2, 5);
    chk("t4_c2_cnt_sat", int'(cnt_c2), 3);
    chk("t4_ov_cnt", int'(cnt_ov), 5);

    // 5: match in the same cycle as clr
    feed("101");
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_det", int'(det_ov), 1);
    chk("t5_cnt", int'(cnt_ov), 0);
    chk("t5_seen", int'(seen_ov), 0);

    // 6: reset mid-stream loses the partial match
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    clear_tally();
    feed("101");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_rst_cnt", int'(cnt_ov), 0);
    feed("1");
    chk("t6_no_det", t_ov, 0);
    feed("011");
    chk("t6_after_det", t_ov, 1);

    // Random mix of gaps, clears and occasional resets
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, $urandom_range(1, 0) == 1,
          ($urandom % 20) == 0, ($urandom % 64) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
